// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory arbiter.
// The RAM is a single-port 64x16 array shared by fetch and loader.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_e;

    localparam int IMEM_AW         = 6;
    localparam int IMEM_DW         = 16;
    localparam int IMEM_STARVE_MAX = 4;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of cycles the loader lost to fetch.
// Clear wins over increment.
module imem_starve_ctr
    import imem_pkg::*;
#(
    parameter int MAX = IMEM_STARVE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    assign sat = (cnt == CW'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction RAM between fetch and the program loader,
// with a RUN/DRAIN/LOAD mode sequence and bounded loader starvation.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int AW         = IMEM_AW,
    parameter int DW         = IMEM_DW,
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req_i,
    input  logic [15:0]   fetch_addr_i,
    output logic          fetch_gnt_o,
    output logic          fetch_rvalid_o,
    output logic [DW-1:0] fetch_rdata_o,
    output logic          fetch_err_o,
    input  logic          load_start_i,
    input  logic          load_done_i,
    input  logic          load_req_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [DW-1:0] load_wdata_i,
    output logic          load_gnt_o,
    output logic          mode_load_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    imem_state_e state;

    logic mode_load_q;
    logic rvalid_q;
    logic err_q;
    logic in_run;
    logic in_load;
    logic illegal;
    logic starve_sat;
    logic fetch_gnt;
    logic load_gnt;

    // Combinational grants are forced low while reset is held.
    assign in_run  = rst_n && (state == ST_RUN);
    assign in_load = rst_n && (state == ST_LOAD);

    assign illegal = fetch_addr_i[0] ||
                     ((fetch_addr_i >> (AW + 1)) != 16'd0);

    assign fetch_gnt = in_run && fetch_req_i &&
                       !(load_req_i && starve_sat);
    assign load_gnt  = load_req_i &&
                       (in_load || (in_run && !fetch_gnt));

    assign fetch_gnt_o = fetch_gnt;
    assign load_gnt_o  = load_gnt;

    imem_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fetch_gnt && load_req_i),
        .clr   (load_gnt || !load_req_i),
        .sat   (starve_sat)
    );

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (load_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = load_addr_i;
            mem_wdata_o = load_wdata_i;
        end else if (fetch_gnt && !illegal) begin
            mem_en_o   = 1'b1;
            mem_addr_o = fetch_addr_i[AW:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            mode_load_q <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (load_start_i) begin
                        state       <= ST_DRAIN;
                        mode_load_q <= 1'b1;
                    end
                end
                // One idle cycle lets a read granted in RUN return.
                ST_DRAIN: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_done_i) begin
                        state       <= ST_RUN;
                        mode_load_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    mode_load_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= fetch_gnt;
            err_q    <= fetch_gnt && illegal;
        end
    end

    assign mode_load_o    = mode_load_q;
    assign fetch_rvalid_o = rvalid_q;
    assign fetch_err_o    = err_q;
    assign fetch_rdata_o  = (rvalid_q && !err_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 64x16 RAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_imem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fetch_req_i;
    logic [15:0] fetch_addr_i;
    logic        fetch_gnt_o;
    logic        fetch_rvalid_o;
    logic [15:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        load_start_i;
    logic        load_done_i;
    logic        load_req_i;
    logic [5:0]  load_addr_i;
    logic [15:0] load_wdata_i;
    logic        load_gnt_o;
    logic        mode_load_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [5:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;

    logic [15:0] ram [64];

    int n_chk;
    int n_fail;

    imem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_gnt_o    (fetch_gnt_o),
        .fetch_rvalid_o (fetch_rvalid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .load_start_i   (load_start_i),
        .load_done_i    (load_done_i),
        .load_req_i     (load_req_i),
        .load_addr_i    (load_addr_i),
        .load_wdata_i   (load_wdata_i),
        .load_gnt_o     (load_gnt_o),
        .mode_load_o    (mode_load_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= ram[mem_addr_o];
        end
    end

    task automatic chk_b(input string tag, input logic obs,
                         input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) ram[i] = 16'h1000 + 16'(i);
        mem_rdata_i  = 16'h0;
        rst_n        = 1'b0;
        fetch_req_i  = 1'b0;
        fetch_addr_i = 16'h0;
        load_start_i = 1'b0;
        load_done_i  = 1'b0;
        load_req_i   = 1'b0;
        load_addr_i  = 6'd0;
        load_wdata_i = 16'h0;

        // Reset: combinational outputs held low despite requests.
        #3;
        fetch_req_i = 1'b1;
        load_req_i  = 1'b1;
        #1;
        chk_b("rst_fgnt", fetch_gnt_o, 1'b0);
        chk_b("rst_lgnt", load_gnt_o, 1'b0);
        chk_b("rst_en", mem_en_o, 1'b0);
        chk_b("rst_rvalid", fetch_rvalid_o, 1'b0);
        chk_b("rst_err", fetch_err_o, 1'b0);
        chk_b("rst_mode", mode_load_o, 1'b0);
        @(negedge clk);
        rst_n       = 1'b1;
        fetch_req_i = 1'b0;
        load_req_i  = 1'b0;

        // Back-to-back legal fetches of words 0, 1, 2.
        @(negedge clk);
        fetch_req_i  = 1'b1;
        fetch_addr_i = 16'h0000;
        #1;
        chk_b("f0_gnt", fetch_gnt_o, 1'b1);
        chk_b("f0_en", mem_en_o, 1'b1);
        chk_b("f0_we", mem_we_o, 1'b0);
        chk_w("f0_addr", 16'(mem_addr_o), 16'd0);
        @(negedge clk);
        chk_b("f0_rv", fetch_rvalid_o, 1'b1);
        chk_b("f0_err", fetch_err_o, 1'b0);
        chk_w("f0_data", fetch_rdata_o, 16'h1000);
        fetch_addr_i = 16'h0002;
        #1;
        chk_b("f1_gnt", fetch_gnt_o, 1'b1);
        chk_w("f1_addr", 16'(mem_addr_o), 16'd1);
        @(negedge clk);
        chk_b("f1_rv", fetch_rvalid_o, 1'b1);
        chk_w("f1_data", fetch_rdata_o, 16'h1001);
        fetch_addr_i = 16'h0004;
        #1;
        chk_w("f2_addr", 16'(mem_addr_o), 16'd2);
        @(negedge clk);
        chk_b("f2_rv", fetch_rvalid_o, 1'b1);
        chk_w("f2_data", fetch_rdata_o, 16'h1002);
        fetch_req_i = 1'b0;
        #1;
        chk_b("idle_gnt", fetch_gnt_o, 1'b0);
        chk_b("idle_en", mem_en_o, 1'b0);
        @(negedge clk);
        chk_b("idle_rv", fetch_rvalid_o, 1'b0);

        // Misaligned, then out-of-range fetch.
        fetch_req_i  = 1'b1;
        fetch_addr_i = 16'h0003;
        #1;
        chk_b("mis_gnt", fetch_gnt_o, 1'b1);
        chk_b("mis_en", mem_en_o, 1'b0);
        @(negedge clk);
        chk_b("mis_rv", fetch_rvalid_o, 1'b1);
        chk_b("mis_err", fetch_err_o, 1'b1);
        chk_w("mis_data", fetch_rdata_o, 16'h0000);
        fetch_addr_i = 16'h0080;
        #1;
        chk_b("oor_gnt", fetch_gnt_o, 1'b1);
        chk_b("oor_en", mem_en_o, 1'b0);
        @(negedge clk);
        chk_b("oor_rv", fetch_rvalid_o, 1'b1);
        chk_b("oor_err", fetch_err_o, 1'b1);
        chk_w("oor_data", fetch_rdata_o, 16'h0000);

        // Starvation: fetch wins four cycles, loader forced on the fifth.
        fetch_addr_i = 16'h0000;
        load_req_i   = 1'b1;
        load_addr_i  = 6'd5;
        load_wdata_i = 16'hA5A5;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_b("stv_fgnt", fetch_gnt_o, 1'b1);
            chk_b("stv_lgnt", load_gnt_o, 1'b0);
            @(negedge clk);
            #1;
        end
        chk_b("stv5_lgnt", load_gnt_o, 1'b1);
        chk_b("stv5_fgnt", fetch_gnt_o, 1'b0);
        chk_b("stv5_we", mem_we_o, 1'b1);
        chk_w("stv5_addr", 16'(mem_addr_o), 16'd5);
        chk_w("stv5_wdata", mem_wdata_o, 16'hA5A5);
        @(negedge clk);
        chk_b("stv5_rv", fetch_rvalid_o, 1'b0);
        load_req_i   = 1'b0;
        fetch_addr_i = 16'h000A;
        #1;
        chk_b("rdbk_gnt", fetch_gnt_o, 1'b1);
        chk_w("rdbk_addr", 16'(mem_addr_o), 16'd5);
        @(negedge clk);
        chk_w("rdbk_data", fetch_rdata_o, 16'hA5A5);

        // load_start during a fetch grant; drain, three writes, done.
        fetch_addr_i = 16'h0002;
        load_start_i = 1'b1;
        #1;
        chk_b("ls_fgnt", fetch_gnt_o, 1'b1);
        @(negedge clk);
        load_start_i = 1'b0;
        load_req_i   = 1'b1;
        load_addr_i  = 6'd10;
        load_wdata_i = 16'h1111;
        chk_b("dr_rv", fetch_rvalid_o, 1'b1);
        chk_w("dr_data", fetch_rdata_o, 16'h1001);
        chk_b("dr_mode", mode_load_o, 1'b1);
        #1;
        chk_b("dr_fgnt", fetch_gnt_o, 1'b0);
        chk_b("dr_lgnt", load_gnt_o, 1'b0);
        chk_b("dr_en", mem_en_o, 1'b0);
        @(negedge clk);
        chk_b("ld_rv", fetch_rvalid_o, 1'b0);
        for (int j = 0; j < 3; j++) begin
            load_addr_i  = 6'd10 + 6'(j);
            load_wdata_i = 16'h2220 + 16'(j);
            #1;
            chk_b("ld_lgnt", load_gnt_o, 1'b1);
            chk_b("ld_fgnt", fetch_gnt_o, 1'b0);
            chk_w("ld_addr", 16'(mem_addr_o), 16'd10 + 16'(j));
            @(negedge clk);
        end
        load_req_i  = 1'b0;
        load_done_i = 1'b1;
        #1;
        chk_b("done_fgnt", fetch_gnt_o, 1'b0);
        chk_b("done_mode", mode_load_o, 1'b1);
        @(negedge clk);
        load_done_i  = 1'b0;
        fetch_addr_i = 16'h0016;
        chk_b("run_mode", mode_load_o, 1'b0);
        #1;
        chk_b("run_fgnt", fetch_gnt_o, 1'b1);
        @(negedge clk);
        chk_w("run_data", fetch_rdata_o, 16'h2221);

        // Reset with a read return pending and starve count at 3.
        fetch_addr_i = 16'h0000;
        load_req_i   = 1'b1;
        load_addr_i  = 6'd20;
        repeat (3) @(negedge clk);
        chk_b("pre_rv", fetch_rvalid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_b("ar_rv", fetch_rvalid_o, 1'b0);
        chk_b("ar_fgnt", fetch_gnt_o, 1'b0);
        chk_b("ar_lgnt", load_gnt_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_b("rs_fgnt", fetch_gnt_o, 1'b1);
            chk_b("rs_lgnt", load_gnt_o, 1'b0);
            @(negedge clk);
            #1;
        end
        chk_b("rs5_lgnt", load_gnt_o, 1'b1);
        @(negedge clk);
        fetch_req_i = 1'b0;
        load_req_i  = 1'b0;

        // Reset in the middle of LOAD.
        load_start_i = 1'b1;
        @(negedge clk);
        load_start_i = 1'b0;
        @(negedge clk);
        chk_b("ml_mode", mode_load_o, 1'b1);
        fetch_req_i = 1'b1;
        load_req_i  = 1'b1;
        #1;
        chk_b("ml_lgnt", load_gnt_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_b("mr_lgnt", load_gnt_o, 1'b0);
        chk_b("mr_fgnt", fetch_gnt_o, 1'b0);
        chk_b("mr_en", mem_en_o, 1'b0);
        chk_b("mr_we", mem_we_o, 1'b0);
        chk_w("mr_addr", 16'(mem_addr_o), 16'd0);
        chk_b("mr_mode", mode_load_o, 1'b0);
        @(negedge clk);
        rst_n      = 1'b1;
        load_req_i = 1'b0;
        #1;
        chk_b("post_fgnt", fetch_gnt_o, 1'b1);
        @(negedge clk);
        chk_b("post_rv", fetch_rvalid_o, 1'b1);
        chk_b("post_mode", mode_load_o, 1'b0);
        fetch_req_i = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port 64×16 instruction RAM between the CPU fetch stage and the program loader (debug/boot channel). It sequences three modes: normal run, a drain step, and exclusive load. It arbitrates per cycle with fetch priority and bounded loader starvation. It also converts the fetch byte address to a word index and flags illegal fetches. The block sits between the PC/fetch logic and the instruction RAM; decode consumes `fetch_rdata_o`.

## Interface
- `AW`, 6: RAM word-address width (64 words).
- `DW`, 16: instruction width.
- `STARVE_MAX`, 4: consecutive lost cycles before the loader is forced through in RUN.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_req_i`  in  1  fetch request; held until granted.
- `fetch_addr_i`  in  16  byte address; word index = `fetch_addr_i >> 1`.
- `fetch_gnt_o`  out  1  combinational grant, same cycle as the request.
- `fetch_rvalid_o`  out  1  read data valid, registered.
- `fetch_rdata_o`  out  DW  instruction word; 0 when `fetch_err_o` is set.
- `fetch_err_o`  out  1  qualifies `fetch_rvalid_o`: misaligned or out-of-range fetch.
- `load_start_i`  in  1  pulse that enters LOAD mode.
- `load_done_i`  in  1  pulse that returns to RUN.
- `load_req_i`  in  1  write request; held until granted.
- `load_addr_i`  in  AW  word address.
- `load_wdata_i`  in  DW  write data.
- `load_gnt_o`  out  1  combinational grant; the write commits on that edge.
- `mode_load_o`  out  1  high in DRAIN and LOAD.
- `mem_en_o`  out  1  RAM enable.
- `mem_we_o`  out  1  RAM write enable.
- `mem_addr_o`  out  AW  RAM address.
- `mem_wdata_o`  out  DW  RAM write data.
- `mem_rdata_i`  in  DW  RAM read data; 1-cycle latency after `mem_en_o` with `mem_we_o`=0.

## Operation
- **States:**
  - RUN (reset state).
  - RUN→DRAIN on `load_start_i`.
  - DRAIN→LOAD after one cycle, so any outstanding read returns.
  - LOAD→RUN on `load_done_i`.
  - `load_start_i` is ignored outside RUN; `load_done_i` is ignored outside LOAD.
- **RUN:**
  - Fetch has priority, except when `starve_cnt == STARVE_MAX` and `load_req_i`=1; then the loader is granted and fetch waits.
  - `starve_cnt` increments each cycle that `load_req_i`=1 and fetch is granted.
  - It clears on a load grant or when `load_req_i`=0.
  - It saturates at `STARVE_MAX`.
- **DRAIN:** no grants; `mem_en_o`=0.
- **LOAD:** only the loader is granted (every cycle `load_req_i`=1); `fetch_gnt_o`=0.
- **Illegal fetch:**
  - Condition: `fetch_addr_i[0]`=1 or `fetch_addr_i[15:AW+1]` ≠ 0.
  - Still granted (same priority rules), with `mem_en_o`=0.
  - Next cycle: `fetch_rvalid_o`=1, `fetch_err_o`=1, `fetch_rdata_o`=0.
- **Legal fetch grant:** `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`=`fetch_addr_i[AW:1]`.
- **Load grant:** `mem_en_o`=1, `mem_we_o`=1, address and data from the `load_*` inputs.
- **No grant:** `mem_*` outputs are 0.
- At most one grant per cycle.

## Timing
- Grant is combinational, in the request cycle N.
- Read data is valid in N+1: `fetch_rdata_o` = `mem_rdata_i` while the registered `rvalid` is set, else 0.
- A write granted in N is visible to a fetch granted in N+1 or later.
- **Reset (asserted at any time, including mid-load):**
  - State RUN, `starve_cnt`=0.
  - `fetch_rvalid_o`=0, `fetch_err_o`=0, `mode_load_o`=0.
  - Any pending read return is discarded.
  - All combinational outputs are 0 while `rst_n`=0.
- `load_start_i` arriving in the same cycle as a fetch grant: the grant completes, rvalid appears in DRAIN, and LOAD begins the cycle after.
- Back-to-back fetches sustain one word per cycle.

## Structure
- Shared package `imem_pkg`:
  - state enum {RUN, DRAIN, LOAD}
  - `IMEM_AW`=6, `IMEM_DW`=16
  - `IMEM_STARVE_MAX`=4
- One sub-module, `imem_starve_ctr` (saturating counter with clear). Everything else is inline: the FSM, the grant mux, and the rvalid/err registers.

## Test plan
- **Reset, then fetch 0x0000, 0x0002, 0x0004 back-to-back:** grants in cycles 1–3; rvalid in 2–4 with RAM words 0, 1, 2; `err`=0.
- **Fetch 0x0003, then 0x0080:** both granted with `mem_en_o`=0; next-cycle rvalid=1, `err`=1, rdata=0 each time.
- **RUN with continuous fetch and loader requesting addr 5, data 0xA5A5:**
  - Fetch wins 4 cycles, then the loader is granted in cycle 5.
  - A fetch of 0x000A afterwards returns 0xA5A5.
- **`load_start_i` during a fetch grant:**
  - rvalid is delivered in DRAIN; `mode_load_o`=1.
  - Fetch is blocked in LOAD while 3 writes are granted consecutively.
  - `load_done_i` returns to RUN and fetch resumes next cycle.
- **Reset mid-LOAD with a pending read:** outputs go to 0 immediately, no rvalid after release, state RUN, starve counter 0.
